// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
//   Shared types and constants for the two-requester SRAM arbiter.
//   - state_t    : controller FSM states
//   - NREQ       : number of requesters (fixed at 2)
//   - OP_RD/OP_WR: encoding of the per-requester req_we bit
//   - idx2onehot : turns a requester index into its one-hot bit
// -----------------------------------------------------------------------------
package sram_arb_pkg;

  localparam int NREQ = 2;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESP
  } state_t;

  function automatic logic [NREQ-1:0] idx2onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Combinational two-way round-robin picker. A lone request always wins;
//   when both requesters ask, prio names the winner.
//   Ports:
//     req     in  [1:0]  request vector, bit i = requester i
//     prio    in         winner when both bits of req are set
//     gnt     out [1:0]  one-hot grant, zero when req is zero
//     gnt_idx out        index of the granted requester (0 when nobody asks)
// -----------------------------------------------------------------------------
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            prio,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_idx
);

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned -- otherwise always_comb would infer a latch.
  always_comb begin
    gnt_idx = 1'b0;
    gnt     = '0;
    unique case (req)
      2'b01: gnt_idx = 1'b0;
      2'b10: gnt_idx = 1'b1;
      2'b11: gnt_idx = prio;
      default: gnt_idx = 1'b0;
    endcase
    if (req != '0) gnt = idx2onehot(gnt_idx);
  end

endmodule

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//   Two-requester round-robin access controller for a single-port
//   synchronous SRAM. One transaction is in flight at a time:
//     write: IDLE -> ISSUE -> RESP -> IDLE            (3 cycles)
//     read : IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE (4 cycles)
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     req_valid/ready  per-requester handshake (ready only in IDLE)
//     req_we           per-requester op, 1 = write
//     req_addr/wdata   packed per-requester address / write data
//     rsp_valid        one-cycle one-hot response pulse to the owner
//     rsp_rdata        read data (0 for write acks), held between responses
//     sram_we/rd/addr/din, sram_dout   SRAM pin interface
// -----------------------------------------------------------------------------
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADR = 3,
  parameter int DAT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ-1:0]     req_we,
  input  logic [NREQ*ADR-1:0] req_addr,
  input  logic [NREQ*DAT-1:0] req_wdata,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [DAT-1:0]      rsp_rdata,
  output logic                sram_we,
  output logic                sram_rd,
  output logic [ADR-1:0]      sram_addr,
  output logic [DAT-1:0]      sram_din,
  input  logic [DAT-1:0]      sram_dout
);

  state_t          state;
  logic            prio;
  logic            owner;
  logic [NREQ-1:0] gnt;
  logic            gnt_idx;

  logic            sel_we;
  logic [ADR-1:0]  sel_addr;
  logic [DAT-1:0]  sel_wdata;

  rr_arb2 u_pick (
    .req     (req_valid),
    .prio    (prio),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Ready is only offered while idle, and never while reset is held even
  // though the state register already reads IDLE then.
  assign req_ready = (rst_n && state == IDLE) ? gnt : '0;

  assign sel_we    = req_we[gnt_idx];
  assign sel_addr  = gnt_idx ? req_addr[2*ADR-1:ADR]  : req_addr[ADR-1:0];
  assign sel_wdata = gnt_idx ? req_wdata[2*DAT-1:DAT] : req_wdata[DAT-1:0];

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values and the block order is irrelevant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      owner     <= 1'b0;
      sram_we   <= 1'b0;
      sram_rd   <= 1'b0;
      sram_addr <= '0;
      sram_din  <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Any valid bit here is a handshake since ready follows gnt.
          if (req_valid != '0) begin
            owner     <= gnt_idx;
            prio      <= ~gnt_idx;
            sram_we   <= (sel_we == OP_WR);
            sram_rd   <= (sel_we == OP_RD);
            sram_addr <= sel_addr;
            sram_din  <= sel_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // The SRAM acts on this edge; sram_we still tells us which op it was.
          sram_we <= 1'b0;
          sram_rd <= 1'b0;
          if (sram_we) begin
            rsp_rdata <= '0;
            rsp_valid <= idx2onehot(owner);
            state     <= RESP;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_rdata <= sram_dout;
          rsp_valid <= idx2onehot(owner);
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
//   Drives sram_arbiter from two scripted/random requesters, models the
//   attached 8 x 8 SRAM, and predicts every pin from a transaction-level
//   model: a memory array, a round-robin priority bit, and a queue of
//   expected responses with their due cycles.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

  localparam int ADR  = 3;
  localparam int DAT  = 8;
  localparam int DPTH = 8;

  typedef struct {
    int             at;
    int             idx;
    logic [DAT-1:0] data;
  } rsp_t;

  typedef struct {
    logic           we;
    logic [ADR-1:0] addr;
    logic [DAT-1:0] wd;
  } txn_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, req_we, rsp_valid;
  logic [2*ADR-1:0] req_addr;
  logic [2*DAT-1:0] req_wdata;
  logic [DAT-1:0]   rsp_rdata, sram_din, sram_dout;
  logic             sram_we, sram_rd;
  logic [ADR-1:0]   sram_addr;

  sram_arbiter #(.ADR(ADR), .DAT(DAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .sram_we   (sram_we),
    .sram_rd   (sram_rd),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
  );

  always #5 clk = ~clk;

  // Single-port synchronous SRAM: write or registered read on the rising edge.
  // NOTE: the storage array has no reset; its contents survive rst_n just like
  // a real SRAM macro, so only the controller state returns to known values.
  logic [DAT-1:0] sram_mem [0:DPTH-1];
  initial begin
    for (int i = 0; i < DPTH; i++) sram_mem[i] = '0;
    sram_dout = '0;
  end
  always @(posedge clk) begin
    if (sram_we) sram_mem[sram_addr] <= sram_din;
    if (sram_rd) sram_dout <= sram_mem[sram_addr];
  end

  // ---------------------------------------------------------------- model
  logic [DAT-1:0] mdl_mem [0:DPTH-1];
  rsp_t           exp_q[$];
  txn_t           script0[$], script1[$];
  int             grant_log[$];
  int             cyc, next_idle, issue_at;
  logic           mprio, iss_we;
  logic [ADR-1:0] iss_addr;
  logic [DAT-1:0] iss_din, last_rdata;
  logic [1:0]     pv, pwe, hs;
  logic [ADR-1:0] paddr [2];
  logic [DAT-1:0] pwd [2];
  bit             rand_mode, log_on;
  int             n_vec, n_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive();
    req_valid = pv;
    req_we    = pwe;
    req_addr  = {paddr[1], paddr[0]};
    req_wdata = {pwd[1], pwd[0]};
  endtask

  task automatic load(input int i, input txn_t t);
    pv[i] = 1'b1; pwe[i] = t.we; paddr[i] = t.addr; pwd[i] = t.wd;
  endtask

  task automatic push(input int i, input logic we, input int addr, input int wd);
    txn_t t;
    t.we = we; t.addr = ADR'(addr); t.wd = DAT'(wd);
    if (i == 0) script0.push_back(t); else script1.push_back(t);
  endtask

  // Requesters with nothing pending take the next scripted or random request;
  // in random mode a pending, ungranted request may also be withdrawn.
  task automatic refill();
    txn_t t;
    for (int i = 0; i < 2; i++) begin
      if (!pv[i]) begin
        if (i == 0 && script0.size() > 0) load(i, script0.pop_front());
        else if (i == 1 && script1.size() > 0) load(i, script1.pop_front());
        else if (rand_mode && $urandom_range(1) == 1) begin
          t.we = 1'($urandom_range(1)); t.addr = ADR'($urandom_range(DPTH-1));
          t.wd = DAT'($urandom_range(255));
          load(i, t);
        end
      end else if (rand_mode && $urandom_range(15) == 0) begin
        pv[i] = 1'b0;
      end
    end
  endtask

  // One clock: new inputs just after the rising edge, all checks at the
  // falling edge. A request granted at this falling edge hands over at the
  // next rising edge and is released right after it.
  task automatic cycle();
    logic [1:0] exp_rdy, exp_rv;
    int g;
    @(posedge clk); #1;
    pv = pv & ~hs;
    hs = '0;
    refill();
    drive();
    @(negedge clk);
    cyc++;

    if (issue_at == cyc) begin
      check("sram_we", sram_we, iss_we);
      check("sram_rd", sram_rd, !iss_we);
      check("sram_addr", sram_addr, iss_addr);
      if (iss_we) check("sram_din", sram_din, iss_din);
    end else begin
      check("sram_we_quiet", sram_we, 0);
      check("sram_rd_quiet", sram_rd, 0);
    end

    exp_rv = '0;
    if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
      exp_rv     = 2'b01 << exp_q[0].idx;
      last_rdata = exp_q[0].data;
      void'(exp_q.pop_front());
    end
    check("rsp_valid", rsp_valid, exp_rv);
    check(exp_rv != '0 ? "rsp_rdata" : "rsp_rdata_hold", rsp_rdata, last_rdata);

    exp_rdy = '0;
    if (cyc >= next_idle && pv != '0) begin
      g = (pv == 2'b11) ? int'(mprio) : (pv[1] ? 1 : 0);
      exp_rdy = 2'b01 << g;
      hs      = exp_rdy;
      if (log_on && req_ready != '0) grant_log.push_back(req_ready[1] ? 1 : 0);
      iss_we = pwe[g]; iss_addr = paddr[g]; iss_din = pwd[g]; issue_at = cyc + 1;
      if (pwe[g]) begin
        mdl_mem[paddr[g]] = pwd[g];
        exp_q.push_back('{cyc + 2, g, '0});
        next_idle = cyc + 3;
      end else begin
        exp_q.push_back('{cyc + 3, g, mdl_mem[paddr[g]]});
        next_idle = cyc + 4;
      end
      mprio = (g == 0);
    end
    check("req_ready", req_ready, exp_rdy);
  endtask

  // Asserts reset between edges, checks the immediate effect, holds it for
  // n cycles with both valids high, then releases at a falling edge.
  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    #1;
    check("rst_sram_we", sram_we, 0);
    check("rst_sram_rd", sram_rd, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_sram_din", sram_din, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    exp_q.delete(); script0.delete(); script1.delete();
    mprio = 1'b0; next_idle = 0; issue_at = -1; last_rdata = '0;
    pv = '0; hs = '0;
    drive();
    req_valid = 2'b11;
    repeat (n) begin
      @(negedge clk);
      cyc++;
      check("rst_req_ready", req_ready, 0);
    end
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((script0.size() > 0 || script1.size() > 0 || pv != '0 || exp_q.size() > 0)
           && n < bound) begin
      cycle();
      n++;
    end
    if (n >= bound) check("drain_timeout", 1, 0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; rand_mode = 0; log_on = 0;
    pv = '0; pwe = '0; hs = '0;
    for (int i = 0; i < 2; i++) begin paddr[i] = '0; pwd[i] = '0; end
    for (int i = 0; i < DPTH; i++) mdl_mem[i] = '0;
    rst_n = 1'b0;
    drive();
    @(negedge clk);

    // 1. reset, then idle
    apply_reset(3);
    repeat (4) cycle();

    // 2. requester 0 write then read of the same address
    push(0, 1, 5, 8'hA7);
    push(0, 0, 5, 0);
    drain(50);

    // 3. simultaneous requests right after reset: r0 wins first
    cycle();
    apply_reset(2);
    push(0, 1, 2, 8'h11);
    push(1, 0, 2, 0);
    drain(50);

    // 4. sustained contention: grants must alternate starting with r0
    grant_log.delete();
    log_on = 1;
    for (int k = 0; k < 4; k++) begin
      push(0, k[0], k, 8'h40 + k);
      push(1, !k[0], k + 4, 8'h50 + k);
    end
    drain(100);
    log_on = 0;
    check("grant_count", grant_log.size(), 8);
    if (grant_log.size() > 0) check("first_grant", grant_log[0], 0);
    for (int k = 1; k < grant_log.size(); k++)
      check("grant_alternates", grant_log[k] != grant_log[k-1], 1);

    // 5a. reset while a read is being issued: sram_rd drops at once
    cycle();
    push(0, 0, 3, 0);
    cycle();
    cycle();
    apply_reset(2);

    // 5b. reset during CAPTURE: no response, prio back to 0
    push(0, 0, 5, 0);
    repeat (3) cycle();
    apply_reset(2);
    repeat (3) cycle();
    push(1, 1, 6, 8'h5C);
    push(0, 0, 5, 0);
    drain(50);

    // 6. r1 fills every address, r0 reads them back-to-back
    for (int a = 0; a < DPTH; a++) push(1, 1, a, 8'h30 + a);
    drain(100);
    for (int a = 0; a < DPTH; a++) push(0, 0, a, 0);
    drain(100);

    // random mix with withdrawals
    rand_mode = 1;
    repeat (600) cycle();
    rand_mode = 0;
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
